// File: rtl/delay_meter.sv
// Round-trip latency meter: launches a probe pulse and counts edges until the echo returns.
// Optional min/max result tracking is enabled by defining DELAY_METER_MINMAX_EN.
module delay_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1000,
  parameter int PULSE_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 echo_in,
  output logic                 probe_out,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] delay_count
`ifdef DELAY_METER_MINMAX_EN
  ,
  output logic [CNT_WIDTH-1:0] min_count,
  output logic [CNT_WIDTH-1:0] max_count
`endif
);

  localparam int PW_W = (PULSE_WIDTH < 2) ? 1 : $clog2(PULSE_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] TO_C   = CNT_WIDTH'(TIMEOUT);
  localparam logic [PW_W-1:0]      PW_MAX = PW_W'(PULSE_WIDTH);

  if (TIMEOUT < 1 || longint'(TIMEOUT) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_timeout
    $error("delay_meter: TIMEOUT must lie in 1 .. 2**CNT_WIDTH-1");
  end
  if (PULSE_WIDTH < 1) begin : g_bad_pulse
    $error("delay_meter: PULSE_WIDTH must be at least 1");
  end

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [PW_W-1:0]      pw_q;
  logic                 probe_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 to_q;
  logic [CNT_WIDTH-1:0] count_q;
`ifdef DELAY_METER_MINMAX_EN
  logic [CNT_WIDTH-1:0] min_q;
  logic [CNT_WIDTH-1:0] max_q;
`endif

  // cnt_d is the edge index being sampled now; it never exceeds TIMEOUT, so no wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pw_q    <= '0;
      probe_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      count_q <= '0;
`ifdef DELAY_METER_MINMAX_EN
      min_q   <= '1;
      max_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      to_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !echo_in) begin
            state_q <= MEASURE;
            probe_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            pw_q    <= PW_W'(1);
          end
        end
        MEASURE: begin
          cnt_q <= cnt_d;
          // Pulse width runs independently of the echo; termination below overrides it.
          if (pw_q >= PW_MAX) begin
            probe_q <= 1'b0;
          end else begin
            pw_q <= pw_q + 1'b1;
          end
          if (echo_in || cnt_d == TO_C) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            probe_q <= 1'b0;
            done_q  <= 1'b1;
            to_q    <= !echo_in;
            count_q <= cnt_d;
`ifdef DELAY_METER_MINMAX_EN
            // Reset values make the first success land in both registers.
            if (echo_in) begin
              if (cnt_d < min_q) min_q <= cnt_d;
              if (cnt_d > max_q) max_q <= cnt_d;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign probe_out   = probe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = to_q;
  assign delay_count = count_q;
`ifdef DELAY_METER_MINMAX_EN
  assign min_count   = min_q;
  assign max_count   = max_q;
`endif

endmodule

// File: tb/tb_delay_meter.sv
// Self-checking bench for delay_meter: echo path is a configurable shift register on probe_out.
// Min/max outputs are checked when DELAY_METER_MINMAX_EN is defined.
module tb_delay_meter;

  localparam int CW = 16;
  localparam int TO = 20;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          echo_in;
  logic          probe_out;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] delay_count;
`ifdef DELAY_METER_MINMAX_EN
  logic [CW-1:0] min_count;
  logic [CW-1:0] max_count;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 0;
  int          mode     = 2;   // 0: delayed probe, 1: echo stuck high, 2: echo stuck low
  logic [31:0] sh       = '0;
  logic [CW-1:0] exp_min = '1;
  logic [CW-1:0] exp_max = '0;

  delay_meter #(
    .CNT_WIDTH  (CW),
    .TIMEOUT    (TO),
    .PULSE_WIDTH(PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .echo_in    (echo_in),
    .probe_out  (probe_out),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .delay_count(delay_count)
`ifdef DELAY_METER_MINMAX_EN
    ,
    .min_count  (min_count),
    .max_count  (max_count)
`endif
  );

  always #5 clk = ~clk;

  // External delay path: lat register stages between probe_out and echo_in.
  always_ff @(posedge clk) sh <= {sh[30:0], probe_out};

  always_comb begin
    echo_in = 1'b0;
    if (mode == 1) echo_in = 1'b1;
    else if (mode == 0) echo_in = (lat == 0) ? probe_out : sh[lat-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    start = 1'b0;
    repeat (40) tick();
  endtask

  task automatic check_minmax(input string nm);
`ifdef DELAY_METER_MINMAX_EN
    n_checks++;
    if (min_count !== exp_min || max_count !== exp_max) begin
      n_fail++;
      $display("FAIL %s minmax: got min=%0d max=%0d, want min=%0d max=%0d",
               nm, min_count, max_count, exp_min, exp_max);
    end
`endif
  endtask

  // One measurement through a path of l stages; echo is first sampled high at edge l+1.
  task automatic measure(input int l, input bit hold, input string nm);
    int exp_cnt;
    bit exp_to;
    int exp_hi;
    int hi;
    int bc;
    int got;
    exp_cnt = (l + 1 > TO) ? TO : l + 1;
    exp_to  = (l + 1 > TO);
    exp_hi  = (PW < exp_cnt) ? PW : exp_cnt;
    mode  = 0;
    lat   = l;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    hi  = 0;
    bc  = 0;
    got = -1;
    for (int i = 0; i < TO + 5; i++) begin
      if (done) begin
        got = i;
        break;
      end
      hi += int'(probe_out);
      bc += int'(busy);
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (got != exp_cnt) begin
      n_fail++;
      $display("FAIL %s done_edge: got %0d, want %0d", nm, got, exp_cnt);
    end
    n_checks++;
    if (delay_count !== CW'(exp_cnt) || timeout !== exp_to) begin
      n_fail++;
      $display("FAIL %s result: got count=%0d to=%b, want count=%0d to=%b",
               nm, delay_count, timeout, exp_cnt, exp_to);
    end
    n_checks++;
    if (hi != exp_hi || bc != exp_cnt) begin
      n_fail++;
      $display("FAIL %s widths: got probe=%0d busy=%0d, want probe=%0d busy=%0d",
               nm, hi, bc, exp_hi, exp_cnt);
    end
    n_checks++;
    if (busy !== 1'b0 || probe_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_cycle: got busy=%b probe=%b, want 0 0", nm, busy, probe_out);
    end
    if (!exp_to) begin
      if (CW'(exp_cnt) < exp_min) exp_min = CW'(exp_cnt);
      if (CW'(exp_cnt) > exp_max) exp_max = CW'(exp_cnt);
    end
    check_minmax(nm);
    tick();
    n_checks++;
    if (done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0 || delay_count !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b to=%b busy=%b count=%0d, want 0 0 0 %0d",
               nm, done, timeout, busy, delay_count, exp_cnt);
    end
    flush();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    rst     = 1'b0;
    exp_min = '1;
    exp_max = '0;
  endtask

  task automatic test_reset();
    mode = 2;
    do_reset();
    n_checks++;
    if (probe_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 ||
        delay_count !== '0) begin
      n_fail++;
      $display("FAIL reset: got probe=%b busy=%b done=%b to=%b count=%0d, want all 0",
               probe_out, busy, done, timeout, delay_count);
    end
    check_minmax("reset");
  endtask

  task automatic test_wire_echo();
    measure(0, 1'b0, "wire");
  endtask

  task automatic test_delayer();
    measure(5, 1'b0, "delayer4");
    measure(2, 1'b0, "delayer1");
    measure(1, 1'b0, "path1");
  endtask

  task automatic test_timeout();
    measure(25, 1'b0, "timeout");
    measure(19, 1'b0, "echo_on_timeout_edge");
    measure(20, 1'b0, "timeout_edge_plus1");
  endtask

  task automatic test_ignored();
    int bad;
    mode  = 1;
    start = 1'b1;
    bad   = 0;
    repeat (8) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || probe_out !== 1'b0) bad++;
    end
    start = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL start_with_echo_high: got %0d active cycles, want 0", bad);
    end
    mode = 2;
    flush();
    measure(7, 1'b1, "start_held_in_measure");
  endtask

  task automatic test_reset_mid();
    int bad;
    mode  = 0;
    lat   = 9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_min = '1;
    exp_max = '0;
    n_checks++;
    if (probe_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || delay_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got probe=%b busy=%b done=%b count=%0d, want 0 0 0 0",
               probe_out, busy, done, delay_count);
    end
    check_minmax("reset_mid");
    bad = 0;
    repeat (20) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", bad);
    end
    flush();
    measure(9, 1'b0, "after_reset_10");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      measure(int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_minmax();
    do_reset();
    measure(5, 1'b0, "mm6");
    measure(2, 1'b0, "mm3");
    measure(30, 1'b0, "mm_timeout");
`ifdef DELAY_METER_MINMAX_EN
    n_checks++;
    if (min_count !== CW'(3) || max_count !== CW'(6)) begin
      n_fail++;
      $display("FAIL minmax_final: got min=%0d max=%0d, want 3 6", min_count, max_count);
    end
`endif
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_wire_echo();
    test_delayer();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_random();
    test_minmax();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
